// File: rtl/imm_packer.sv
// Scatters a two's-complement immediate into RISC-V I/S/B/U/J fields of an instruction template and queues it in a small FIFO.
// Optional macro IMM_RANGE_CHECK_EN enables range checking, out_err and err_count; otherwise both are tied 0.
module imm_packer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_imm_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Type codes match the ImmExtend decoder's Parameters.v.
  typedef enum logic [2:0] {
    NOTYPE = 3'd0,
    RTYPE  = 3'd1,
    ITYPE  = 3'd2,
    STYPE  = 3'd3,
    BTYPE  = 3'd4,
    UTYPE  = 3'd5,
    JTYPE  = 3'd6
  } imm_type_e;

  imm_type_e   imm_type;
  logic [31:0] enc_inst;

  assign imm_type = imm_type_e'(in_imm_type);

  always_comb begin
    enc_inst = in_inst;
    unique case (imm_type)
      ITYPE: enc_inst[31:20] = in_imm[11:0];
      STYPE: begin
        enc_inst[31:25] = in_imm[11:5];
        enc_inst[11:7]  = in_imm[4:0];
      end
      BTYPE: begin
        enc_inst[31]    = in_imm[12];
        enc_inst[30:25] = in_imm[10:5];
        enc_inst[11:8]  = in_imm[4:1];
        enc_inst[7]     = in_imm[11];
      end
      UTYPE: enc_inst[31:12] = in_imm[31:12];
      JTYPE: begin
        enc_inst[31]    = in_imm[20];
        enc_inst[30:21] = in_imm[10:1];
        enc_inst[20]    = in_imm[11];
        enc_inst[19:12] = in_imm[19:12];
      end
      default: enc_inst = in_inst;
    endcase
  end

  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;
  assign out_inst  = empty ? '0 : data_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) data_q[wptr_q] <= enc_inst;
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic             enc_err;
  logic             err_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    enc_err = 1'b0;
    unique case (imm_type)
      ITYPE, STYPE: enc_err = (in_imm[31:11] != {21{in_imm[11]}});
      BTYPE:        enc_err = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      UTYPE:        enc_err = |in_imm[11:0];
      JTYPE:        enc_err = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      default:      enc_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) err_q[wptr_q] <= enc_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt_q <= '0;
    else if (push && enc_err && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign out_err   = empty ? 1'b0 : err_q[rptr_q];
  assign err_count = cnt_q;
`else
  assign out_err   = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Directed-vector bench for imm_packer: encoding, range errors, FIFO handshake, saturation and async reset.
module tb_imm_packer;

  localparam logic [2:0] T_I = 3'd2, T_S = 3'd3, T_B = 3'd4, T_U = 3'd5, T_J = 3'd6, T_X = 3'd7;
  localparam int unsigned CW = 3;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [31:0]   in_inst = '0, in_imm = '0;
  logic [2:0]    in_imm_type = '0;
  logic          out_valid, out_ready = 1'b0, out_err;
  logic [31:0]   out_inst;
  logic [CW-1:0] err_count;

  int unsigned checks = 0, failures = 0;
  int unsigned exp_cnt = 0;

  imm_packer #(.DEPTH(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_imm(in_imm), .in_imm_type(in_imm_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] imm, input logic [2:0] t);
    in_valid = 1'b1; in_inst = inst; in_imm = imm; in_imm_type = t;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Push one word into an empty FIFO with out_ready=1, check the head, then let it drain.
  task automatic send_check(input string tag, input logic [31:0] inst, input logic [31:0] imm,
                            input logic [2:0] t, input logic [31:0] exp_inst, input bit raw_err);
    bit e;
    int unsigned n;
    e = raw_err & CHK_EN;
    drive(inst, imm, t);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    if (e && exp_cnt < (1 << CW) - 1) exp_cnt++;
    check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_err"}, {31'b0, out_err}, {31'b0, e});
    check({tag, "_cnt"}, {29'b0, err_count}, exp_cnt);
    tick();
    check({tag, "_drain"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();
    check("rst_vld", {31'b0, out_valid}, 32'd0);
    check("rst_rdy", {31'b0, in_ready}, 32'd1);
    check("rst_inst", out_inst, 32'd0);
    check("rst_err", {31'b0, out_err}, 32'd0);
    check("rst_cnt", {29'b0, err_count}, 32'd0);

    out_ready = 1'b1;
    send_check("i_neg4",  32'h00060613, -32'sd4,     T_I, 32'hFFC60613, 0);
    send_check("b_16",    32'h00A98063, 32'd16,      T_B, 32'h00A98863, 0);
    send_check("b_17",    32'h00A98063, 32'd17,      T_B, 32'h00A98863, 1);
    send_check("s_8",     32'h00E12023, 32'd8,       T_S, 32'h00E12423, 0);
    send_check("i_2048",  32'h00060613, 32'd2048,    T_I, 32'h80060613, 1);
    send_check("i_2047",  32'h00000013, 32'd2047,    T_I, 32'h7FF00013, 0);
    send_check("i_m2048", 32'h00000013, -32'sd2048,  T_I, 32'h80000013, 0);
    send_check("u_ok",    32'h00000537, 32'h12345000, T_U, 32'h12345537, 0);
    send_check("u_bad",   32'h00000537, 32'h12345001, T_U, 32'h12345537, 1);
    send_check("j_2048",  32'h0000006F, 32'd2048,    T_J, 32'h0010006F, 0);
    send_check("j_neg2",  32'h0000006F, -32'sd2,     T_J, 32'hFFFFF06F, 0);
    send_check("j_big",   32'h0000006F, 32'h00100000, T_J, 32'h8000006F, 1);
    send_check("other",   32'h12345678, 32'hDEADBEEF, T_X, 32'h12345678, 0);

    // Backpressure: three words against a two-entry FIFO.
    out_ready = 1'b0;
    drive(32'h00000013, 32'd1, T_I); tick();
    drive(32'h00000013, 32'd2, T_I); tick();
    check("bp_full", {31'b0, in_ready}, 32'd0);
    drive(32'h00000013, 32'd3, T_I); tick();
    check("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
    check("bp_hold_head", out_inst, 32'h00100013);
    out_ready = 1'b1; tick();
    check("bp_head1", out_inst, 32'h00200013);
    check("bp_rdy1", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_head2", out_inst, 32'h00300013);
    tick();
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Streaming: one word per cycle, each visible right after its push edge.
    for (int unsigned k = 0; k < 6; k++) begin
      if (k == 5) drive(32'h12345678, 32'd5, T_X);
      else        drive(32'h00000013, k, T_I);
      tick();
      check("st_vld", {31'b0, out_valid}, 32'd1);
      check("st_inst", out_inst, (k == 5) ? 32'h12345678 : (32'h00000013 | (k << 20)));
    end
    in_valid = 1'b0;
    tick();

    // Saturating error counter.
    for (int unsigned k = 0; k < 9; k++)
      send_check("sat", 32'h00000013, 32'd4096, T_I, 32'h00000013, 1);
    check("sat_final", {29'b0, err_count}, CHK_EN ? 32'd7 : 32'd0);

    // Asynchronous reset mid-cycle with two words buffered.
    out_ready = 1'b0;
    drive(32'h00000013, 32'd9, T_I); tick();
    drive(32'h00000013, 32'd10, T_I); tick();
    in_valid = 1'b0;
    check("pre_rst_full", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", {31'b0, out_valid}, 32'd0);
    check("arst_rdy", {31'b0, in_ready}, 32'd1);
    check("arst_inst", out_inst, 32'd0);
    check("arst_cnt", {29'b0, err_count}, 32'd0);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    check("post_rst_vld", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
